// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The queue sits on the slave modport; the fetch/decode side uses master.
interface instr_queue_if #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int PTR_W      = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PC_SIZE-1:0]    in_pc;
  logic [INSTR_SIZE-1:0] in_instr;
  logic                  in_take;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_SIZE-1:0]    out_pc;
  logic [INSTR_SIZE-1:0] out_instr;
  logic                  out_take;
  logic [PTR_W:0]        count;

  modport slave (
    input  in_valid, in_pc, in_instr, in_take, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_take, count
  );

  modport master (
    output in_valid, in_pc, in_instr, in_take, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_take, count
  );
endinterface

// File: rtl/instr_queue.sv
// Circular FIFO decoupling instruction fetch from decode; a redirect (flush)
// empties it in one cycle, and an empty queue presents a NOP bubble.
module instr_queue #(
  parameter int                    DEPTH      = 4,
  parameter int                    PTR_W      = 2,
  parameter int                    PC_SIZE    = 32,
  parameter int                    INSTR_SIZE = 32,
  parameter logic [INSTR_SIZE-1:0] INSTR_NOP  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          iq_rst_n,
  instr_queue_if.slave  iq
);

  localparam int             EW       = PC_SIZE + INSTR_SIZE + 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W:0]              cnt;
  logic [PTR_W:0]              cnt_next;
  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        pop;
  logic [EW-1:0]               in_ent;
  logic [EW-1:0]               rd_ent;
  logic [DEPTH-1:0][EW-1:0]    ent_arr;

  assign full   = (cnt == FULL_CNT);
  assign empty  = (cnt == '0);
  assign push   = iq.in_valid && !full && !iq.flush;
  assign pop    = !empty && iq.out_ready && !iq.flush;
  assign in_ent = {iq.in_pc, iq.in_instr, iq.in_take};

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge iq_rst_n) begin
    if (!iq_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (iq.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_next;
    end
  end

  // Entry storage carries no reset; the empty flag masks whatever it holds.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
      logic [EW-1:0] ent_q;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr == IDX)) ent_q <= in_ent;
      end
      assign ent_arr[gi] = ent_q;
    end
  endgenerate

  assign rd_ent       = ent_arr[rd_ptr];
  assign iq.in_ready  = !full;
  assign iq.out_valid = !empty;
  assign iq.out_pc    = empty ? '0        : rd_ent[EW-1 -: PC_SIZE];
  assign iq.out_instr = empty ? INSTR_NOP : rd_ent[INSTR_SIZE:1];
  assign iq.out_take  = empty ? 1'b0      : rd_ent[0];
  assign iq.count     = cnt;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: accepted pushes are queued as expected
// head entries and checked against out_* when decode consumes them.
module tb_instr_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        take;
  } ent_t;

  logic clk = 1'b0;
  logic iq_rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  bit   saw_200 = 1'b0;
  ent_t exp_q[$];

  instr_queue_if #(.PC_SIZE(32), .INSTR_SIZE(32), .PTR_W(2)) iq();

  instr_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk      (clk),
    .iq_rst_n (iq_rst_n),
    .iq       (iq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (iq.out_valid && iq.out_pc == 32'h200) saw_200 = 1'b1;

  // Advance one cycle; the model decides acceptance from its own occupancy.
  task automatic tick();
    bit   do_push, do_pop, do_flush;
    ent_t e;
    do_flush = iq.flush;
    do_push  = iq.in_valid && (exp_q.size() < DEPTH) && !do_flush;
    do_pop   = (exp_q.size() != 0) && iq.out_ready && !do_flush;
    e = '{pc: iq.in_pc, instr: iq.in_instr, take: iq.in_take};
    @(posedge clk);
    if (do_flush) begin
      exp_q.delete();
      $display("flush");
    end else begin
      if (do_pop) begin
        $display("pop  pc=%08h", exp_q[0].pc);
        void'(exp_q.pop_front());
      end
      if (do_push) begin
        exp_q.push_back(e);
        $display("push pc=%08h instr=%08h take=%0d", e.pc, e.instr, e.take);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic take);
    iq.in_valid = v;
    iq.in_pc    = pc;
    iq.in_instr = $urandom;
    iq.in_take  = take;
  endtask

  task automatic test_reset();
    iq_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    iq_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (iq.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", iq.in_ready); end
      vectors++; if (iq.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", iq.out_valid); end
      vectors++; if (iq.out_instr !== NOP) begin miscompares++; $display("FAIL rst_out_instr got %08h want %08h", iq.out_instr, NOP); end
      vectors++; if (iq.count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", iq.count); end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    iq.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k), k[0]);
      tick();
      vectors++; if (iq.count !== 3'(k + 1)) begin miscompares++; $display("FAIL fill_count got %0d want %0d", iq.count, k + 1); end
    end
    vectors++; if (iq.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got %b want 0", iq.in_ready); end
    drive(1'b1, 32'h10, 1'b1);
    tick();
    vectors++; if (iq.count !== 3'd4) begin miscompares++; $display("FAIL fifth_push_count got %0d want 4", iq.count); end
    drive(1'b0, 32'h0, 1'b0);
    iq.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (iq.out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid got %b want 1", iq.out_valid); end
      vectors++; if (iq.out_pc !== 32'(4 * k) || iq.out_pc !== exp_q[0].pc) begin miscompares++; $display("FAIL drain_pc got %08h want %08h", iq.out_pc, 32'(4 * k)); end
      vectors++; if (iq.out_instr !== exp_q[0].instr || iq.out_take !== exp_q[0].take) begin miscompares++; $display("FAIL drain_payload got %08h/%b want %08h/%b", iq.out_instr, iq.out_take, exp_q[0].instr, exp_q[0].take); end
      tick();
    end
    vectors++; if (iq.out_valid !== 1'b0 || iq.out_instr !== NOP) begin miscompares++; $display("FAIL drained_bubble got %b/%08h want 0/%08h", iq.out_valid, iq.out_instr, NOP); end
  endtask

  task automatic test_stream();
    iq.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), k[1]);
      if (k == 0) begin
        vectors++; if (iq.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_no_bypass got %b want 0", iq.out_valid); end
      end else begin
        vectors++; if (iq.out_valid !== 1'b1 || iq.out_pc !== 32'h100 + 32'(4 * (k - 1)) || iq.out_pc !== exp_q[0].pc) begin miscompares++; $display("FAIL stream_pc got %b/%08h want 1/%08h", iq.out_valid, iq.out_pc, 32'h100 + 32'(4 * (k - 1))); end
        vectors++; if (iq.count !== 3'd1 || iq.out_take !== exp_q[0].take) begin miscompares++; $display("FAIL stream_count got %0d/%b want 1/%b", iq.count, iq.out_take, exp_q[0].take); end
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    vectors++; if (iq.out_pc !== 32'h14C) begin miscompares++; $display("FAIL stream_last got %08h want 0000014c", iq.out_pc); end
    tick();
    vectors++; if (iq.out_valid !== 1'b0 || iq.count !== 3'd0) begin miscompares++; $display("FAIL stream_end got %b/%0d want 0/0", iq.out_valid, iq.count); end
  endtask

  task automatic test_flush();
    iq.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h40 + 32'(4 * k), 1'b1);
      tick();
    end
    drive(1'b1, 32'h200, 1'b1);
    iq.flush = 1'b1;
    tick();
    iq.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    vectors++; if (iq.count !== 3'd0 || iq.out_valid !== 1'b0 || iq.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_full got cnt=%0d v=%b r=%b want 0/0/1", iq.count, iq.out_valid, iq.in_ready); end
    drive(1'b1, 32'h300, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    vectors++; if (iq.out_valid !== 1'b1 || iq.out_pc !== 32'h300 || iq.out_pc !== exp_q[0].pc) begin miscompares++; $display("FAIL post_flush_push got %b/%08h want 1/00000300", iq.out_valid, iq.out_pc); end
    drive(1'b1, 32'h304, 1'b1);
    tick();
    drive(1'b1, 32'h210, 1'b1);
    iq.flush = 1'b1;
    iq.out_ready = 1'b1;
    tick();
    iq.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    vectors++; if (iq.count !== 3'd0 || iq.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_partial got %0d/%b want 0/0", iq.count, iq.out_valid); end
    tick();
    vectors++; if (saw_200 !== 1'b0 || iq.count !== 3'd0) begin miscompares++; $display("FAIL flushed_entry_seen got %b/%0d want 0/0", saw_200, iq.count); end
  endtask

  task automatic test_push_pop();
    iq.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k), 1'b0);
      tick();
    end
    drive(1'b1, 32'h40C, 1'b1);
    iq.out_ready = 1'b1;
    vectors++; if (iq.out_pc !== 32'h400) begin miscompares++; $display("FAIL pp3_head got %08h want 00000400", iq.out_pc); end
    tick();
    vectors++; if (iq.count !== 3'd3 || iq.out_pc !== 32'h404 || iq.out_pc !== exp_q[0].pc) begin miscompares++; $display("FAIL pp3_after got %0d/%08h want 3/00000404", iq.count, iq.out_pc); end
    iq.out_ready = 1'b0;
    drive(1'b1, 32'h410, 1'b0);
    tick();
    drive(1'b1, 32'h414, 1'b0);
    iq.out_ready = 1'b1;
    vectors++; if (iq.in_ready !== 1'b0 || iq.count !== 3'd4) begin miscompares++; $display("FAIL pp4_blocked got %b/%0d want 0/4", iq.in_ready, iq.count); end
    tick();
    drive(1'b0, 32'h0, 1'b0);
    iq.out_ready = 1'b0;
    vectors++; if (iq.count !== 3'd3 || iq.in_ready !== 1'b1 || iq.out_pc !== exp_q[0].pc) begin miscompares++; $display("FAIL pp4_pop got %0d/%b/%08h want 3/1/%08h", iq.count, iq.in_ready, iq.out_pc, exp_q[0].pc); end
    iq.flush = 1'b1;
    tick();
    iq.flush = 1'b0;
  endtask

  task automatic test_async_reset();
    iq.out_ready = 1'b0;
    drive(1'b1, 32'h500, 1'b1);
    tick();
    drive(1'b1, 32'h504, 1'b1);
    tick();
    vectors++; if (iq.count !== 3'd2 || iq.out_take !== 1'b1) begin miscompares++; $display("FAIL arst_pre got %0d/%b want 2/1", iq.count, iq.out_take); end
    drive(1'b1, 32'h508, 1'b1);
    #2 iq_rst_n = 1'b0;
    #1;
    vectors++; if (iq.out_valid !== 1'b0 || iq.count !== 3'd0 || iq.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_async got v=%b cnt=%0d r=%b want 0/0/1", iq.out_valid, iq.count, iq.in_ready); end
    vectors++; if (iq.out_take !== 1'b0 || iq.out_pc !== 32'h0 || iq.out_instr !== NOP) begin miscompares++; $display("FAIL arst_outputs got %b/%08h/%08h want 0/0/%08h", iq.out_take, iq.out_pc, iq.out_instr, NOP); end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    iq_rst_n = 1'b1;
    exp_q.delete();
    vectors++; if (iq.count !== 3'd0 || iq.out_valid !== 1'b0 || iq.out_take !== 1'b0) begin miscompares++; $display("FAIL arst_release got %0d/%b/%b want 0/0/0", iq.count, iq.out_valid, iq.out_take); end
    tick();
    vectors++; if (iq.count !== 3'd0 || iq.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_no_push got %0d/%b want 0/0", iq.count, iq.out_valid); end
  endtask

  initial begin
    iq_rst_n     = 1'b0;
    iq.in_valid  = 1'b0;
    iq.in_pc     = '0;
    iq.in_instr  = '0;
    iq.in_take   = 1'b0;
    iq.flush     = 1'b0;
    iq.out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_flush();
    test_push_pop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_queue.md
# instr_queue

Decoupling queue on the receive side of the fetch stage: accepts `{pc, instr, take}` from instruction fetch and holds it for decode in a small circular FIFO with valid/ready handshakes on both sides. Back-pressure from decode is absorbed here rather than stalling the PC. On any control-flow redirect (`predict_fail` or a resolved `jalr`), all wrong-path entries are discarded in one cycle.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `PTR_W`, default 2: pointer width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `iq_rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents an entry.
- `in_ready`  out  1  queue can accept an entry; equals !full.
- `in_pc`  in  `PC_SIZE`  PC of the fetched instruction.
- `in_instr`  in  `INSTR_SIZE`  fetched instruction word.
- `in_take`  in  1  predecode predicted-taken flag.
- `flush`  in  1  redirect; driven by `predict_fail | id_jalr`.
- `out_valid`  out  1  head entry available to decode.
- `out_ready`  in  1  decode consumes the head entry this cycle.
- `out_pc`  out  `PC_SIZE`  head PC.
- `out_instr`  out  `INSTR_SIZE`  head instruction word.
- `out_take`  out  1  head taken flag.
- `count`  out  `PTR_W`+1  current occupancy, 0..`DEPTH`.

## Operation
- Storage: `DEPTH` registered entries of `{pc, instr, take}`, with write pointer `wr_ptr`, read pointer `rd_ptr` and occupancy `cnt`. Storage registers are not reset.
- Push: when `in_valid & in_ready` and `flush` is 0, write to entry `wr_ptr` and set `wr_ptr <= wr_ptr+1`. Pointers wrap modulo `DEPTH` through natural `PTR_W`-bit overflow.
- Pop: when `out_valid & out_ready` and `flush` is 0, set `rd_ptr <= rd_ptr+1`.
- Occupancy: `cnt` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Flags: `full = (cnt == DEPTH)`, `empty = (cnt == 0)`.
- Flush has highest priority. Within the flush cycle:
  - `wr_ptr`, `rd_ptr` and `cnt` go to 0;
  - any concurrent push is dropped;
  - any concurrent pop is ignored.
- Output path: `out_valid = !empty`.
  - When not empty, `out_pc`, `out_instr` and `out_take` are read combinationally from entry `rd_ptr`.
  - When empty, outputs are forced to `out_pc = 0`, `out_instr = INSTR_NOP`, `out_take = 0`, so decode sees a bubble and never stale data.
- `in_ready` depends only on `cnt`, never combinationally on `out_ready`. There is no full-and-pop pass-through.
- There is no empty bypass: an entry is never forwarded from `in_*` to `out_*` in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` deassert by the reset tree):
  - pointers and `cnt` = 0;
  - `in_ready = 1`, `out_valid = 0`, `count = 0`;
  - `out_pc = 0`, `out_instr = INSTR_NOP`, `out_take = 0`.
- Latency: an entry pushed at edge N drives `out_*` with `out_valid = 1` from edge N onward (one cycle, in to out).
- Throughput: one push and one pop per cycle sustained, including at `cnt = DEPTH-1` and `cnt = 1`.
- Full: `in_ready = 0`. A pop at edge N raises `in_ready` after edge N; the new push is accepted at edge N+1 at the earliest.
- Empty with a simultaneous push: `out_valid` stays 0 this cycle and becomes 1 next cycle.
- Flush at edge N: `out_valid = 0` and `in_ready = 1` after edge N, whatever the prior state (including full). Correct-path fetch may push at edge N+1.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronously). Contents are lost and no partial push completes.
- `count` is a registered value and is always consistent with `out_valid` and `in_ready` in the same cycle.

## Test plan
- Reset then idle: hold `iq_rst_n = 0` for 3 cycles, release, run 5 idle cycles. Required: `in_ready = 1`, `out_valid = 0`, `out_instr = INSTR_NOP`, `count = 0` throughout.
- Fill and drain: `out_ready = 0`, push PCs 0x00, 0x04, 0x08, 0x0C. Required: `count` steps 1..4, `in_ready = 0` after the 4th push, and a 5th `in_valid` is not accepted. Then `out_ready = 1`: PCs come out in order 0x00..0x0C over 4 cycles, then `out_valid = 0`.
- Wrap-around streaming: 20 back-to-back pushes with PCs 0x100 + 4k and `out_ready = 1`. Required: output sequence is identical and in order, `count` stays at 1 after the first push, and there are no bubbles.
- Flush while full, with a concurrent push: queue holds 4 entries, and `flush = 1` coincides with `in_valid = 1` (PC 0x200). Required: next cycle `count = 0`, `out_valid = 0`, and 0x200 is never output. A push of 0x300 on the following cycle appears at `out_pc` one cycle later.
- Simultaneous push and pop at `count = 4` is impossible (`in_ready = 0`). At `count = 3`, push plus pop leaves `count = 3` and the head advances by one entry.
- Asynchronous reset mid-stream: assert `iq_rst_n` between clock edges with `count = 2`. Required: `out_valid` and `count` drop to 0 before the next edge, and `in_take`/`out_take` show no stale value.
